ms_timer_ctrl: RTL and testbench

Multi-channel millisecond timer controller driven by the shared 1 ms clock-enable strobe (ce1ms) from the tick generator. It shares that single tick among NCH independent software-configurable timers. Each timer is one-shot or periodic and raises a one-cycle expire pulse. It sits between the tick generator and the counter/display logic that needs timed events.

---
 rtl/ms_timer_pkg.sv | 21 ++
 rtl/ms_timer_chan.sv | 106 ++++++++++
 rtl/ms_timer_ctrl.sv | 98 +++++++++
 tb/tb_ms_timer_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ms_timer_pkg.sv
// ---------------------------------------------------------------------------
// ms_timer_pkg
// Shared types and constants for the multi-channel millisecond timer.
//   state_t             : per-channel state (ST_IDLE, ST_RUN)
//   MODE_ONESHOT        : channel stops after its first expiry
//   MODE_PERIODIC       : channel reloads its period after each expiry
//   MS_TIMER_CW_DEFAULT : default width of period/count registers in ms
// ---------------------------------------------------------------------------
package ms_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam int MS_TIMER_CW_DEFAULT = 16;

endpackage

// File: rtl/ms_timer_chan.sv
// ---------------------------------------------------------------------------
// ms_timer_chan
// One timer channel. Holds its own period, mode, remaining count and state.
// It counts 1 ms strobes down from the period and raises a one-cycle expire
// pulse when the last millisecond elapses.
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   ce1ms        : shared 1 ms clock-enable strobe
//   cfg_we       : write period/mode of this channel (already decoded)
//   cfg_period   : period in ms, 0 disables the channel
//   cfg_mode     : MODE_ONESHOT or MODE_PERIODIC
//   start, stop  : start/restart and stop requests for this channel
//   busy         : channel is in ST_RUN
//   expire       : one-clk pulse on timeout
//   count        : remaining ms
// ---------------------------------------------------------------------------
module ms_timer_chan
  import ms_timer_pkg::*;
#(
  parameter int CW = MS_TIMER_CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce1ms,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_period,
  input  logic          cfg_mode,
  input  logic          start,
  input  logic          stop,
  output logic          busy,
  output logic          expire,
  output logic [CW-1:0] count
);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] period_q, period_d;
  logic          mode_q, mode_d;
  logic          busy_q, busy_d;
  logic          expire_q, expire_d;

  // Next-state logic. The priority order is stop, then start/restart, then
  // the strobe-driven countdown; a restart therefore swallows an expiry that
  // would otherwise fall in the same cycle. Configuration writes only touch
  // period/mode, so a running count picks them up at its next reload/start.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    mode_d   = mode_q;
    expire_d = 1'b0;

    if (cfg_we) begin
      period_d = cfg_period;
      mode_d   = cfg_mode;
    end

    if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (start && (period_q != '0)) begin
      state_d = ST_RUN;
      cnt_d   = period_q;
    end else if ((state_q == ST_RUN) && ce1ms) begin
      if (cnt_q > CW'(1)) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        // Last millisecond elapsed; a period cleared while running ends the
        // channel rather than reloading a zero count.
        expire_d = 1'b1;
        if ((mode_q == MODE_PERIODIC) && (period_q != '0)) begin
          cnt_d = period_q;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
    end

    busy_d = (state_d == ST_RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      mode_q   <= MODE_ONESHOT;
      busy_q   <= 1'b0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      expire_q <= expire_d;
    end
  end

  assign busy   = busy_q;
  assign expire = expire_q;
  assign count  = cnt_q;

endmodule

// File: rtl/ms_timer_ctrl.sv
// ---------------------------------------------------------------------------
// ms_timer_ctrl
// Multi-channel millisecond timer controller. Shares the 1 ms strobe among
// NCH independent one-shot/periodic timers (ms_timer_chan instances).
// Optional feature macro: MS_TIMER_IRQ_EN adds sticky per-channel interrupt
// pending bits and a combined registered interrupt line.
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   ce1ms        : 1 ms clock-enable strobe, one clk wide
//   cfg_we       : write period/mode of channel cfg_ch (cfg_ch >= NCH ignored)
//   cfg_ch       : channel select for cfg_we
//   cfg_period   : period in ms, 0 disables the channel
//   cfg_mode     : 0 one-shot, 1 periodic
//   start, stop  : per-channel start/restart and stop requests
//   busy         : per-channel running flag
//   expire       : per-channel one-clk timeout pulse
//   count        : remaining ms per channel, channel 0 in the LSBs
//   irq_clr      : (MS_TIMER_IRQ_EN) per-channel pending clear
//   irq_pend     : (MS_TIMER_IRQ_EN) per-channel pending flags
//   irq          : (MS_TIMER_IRQ_EN) OR of pending flags, registered
// ---------------------------------------------------------------------------
module ms_timer_ctrl
  import ms_timer_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = MS_TIMER_CW_DEFAULT,
  parameter int CHW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce1ms,
  input  logic              cfg_we,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [CW-1:0]     cfg_period,
  input  logic              cfg_mode,
  input  logic [NCH-1:0]    start,
  input  logic [NCH-1:0]    stop,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    expire,
  output logic [NCH*CW-1:0] count
`ifdef MS_TIMER_IRQ_EN
  ,
  input  logic [NCH-1:0]    irq_clr,
  output logic [NCH-1:0]    irq_pend,
  output logic              irq
`endif
);

  logic [NCH-1:0] chan_we;

  // One channel per generate iteration. The write decode compares against
  // the channel index only, so out-of-range selects hit no channel.
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign chan_we[i] = cfg_we && (cfg_ch == CHW'(i));

    ms_timer_chan #(
      .CW(CW)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .ce1ms      (ce1ms),
      .cfg_we     (chan_we[i]),
      .cfg_period (cfg_period),
      .cfg_mode   (cfg_mode),
      .start      (start[i]),
      .stop       (stop[i]),
      .busy       (busy[i]),
      .expire     (expire[i]),
      .count      (count[i*CW +: CW])
    );
  end

`ifdef MS_TIMER_IRQ_EN
  logic [NCH-1:0] irq_pend_q, irq_pend_d;
  logic           irq_q, irq_d;

  // Pending bits are set by the expire pulse and cleared by software; a set
  // arriving with a clear wins so no timeout is ever lost.
  always_comb begin
    irq_pend_d = (irq_pend_q & ~irq_clr) | expire;
    irq_d      = |irq_pend_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_pend_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_pend_q <= irq_pend_d;
      irq_q      <= irq_d;
    end
  end

  assign irq_pend = irq_pend_q;
  assign irq      = irq_q;
`endif

endmodule

// File: tb/tb_ms_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ms_timer_ctrl
// Self-checking bench for ms_timer_ctrl: directed scenarios followed by a
// randomized phase, all compared every cycle against a behavioural model of
// the timer rules (remaining ms per channel, run flag, sticky pending).
// Optional feature macro: MS_TIMER_IRQ_EN enables the interrupt checks.
// ---------------------------------------------------------------------------
module tb_ms_timer_ctrl;

  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int CHW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ce1ms;
  logic              cfg_we;
  logic [CHW-1:0]    cfg_ch;
  logic [CW-1:0]     cfg_period;
  logic              cfg_mode;
  logic [NCH-1:0]    start;
  logic [NCH-1:0]    stop;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    expire;
  logic [NCH*CW-1:0] count;
`ifdef MS_TIMER_IRQ_EN
  logic [NCH-1:0]    irq_clr;
  logic [NCH-1:0]    irq_pend;
  logic              irq;
`endif

  int checks = 0;
  int fails  = 0;

  // Reference model state: period/mode registers, remaining ms, running
  // flag, the expire pulse currently visible and the sticky pending flags.
  int m_period [NCH];
  int m_mode   [NCH];
  int m_rem    [NCH];
  bit m_run    [NCH];
  bit m_exp    [NCH];
  bit m_pend   [NCH];

  ms_timer_ctrl #(
    .NCH(NCH),
    .CW (CW),
    .CHW(CHW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce1ms      (ce1ms),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_mode   (cfg_mode),
    .start      (start),
    .stop       (stop),
    .busy       (busy),
    .expire     (expire),
    .count      (count)
`ifdef MS_TIMER_IRQ_EN
    ,
    .irq_clr    (irq_clr),
    .irq_pend   (irq_pend),
    .irq        (irq)
`endif
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] expected);
    checks++;
    if (obs !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, expected, $time);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < NCH; i++) begin
      m_period[i] = 0;
      m_mode[i]   = 0;
      m_rem[i]    = 0;
      m_run[i]    = 1'b0;
      m_exp[i]    = 1'b0;
      m_pend[i]   = 1'b0;
    end
  endfunction

  // Advance the model by one clock edge using the stimulus currently driven.
  function automatic void modelStep();
    for (int i = 0; i < NCH; i++) begin
`ifdef MS_TIMER_IRQ_EN
      m_pend[i] = (m_pend[i] && !irq_clr[i]) || m_exp[i];
`endif
      m_exp[i] = 1'b0;
      if (stop[i]) begin
        m_run[i] = 1'b0;
        m_rem[i] = 0;
      end else if (start[i] && m_period[i] != 0) begin
        m_run[i] = 1'b1;
        m_rem[i] = m_period[i];
      end else if (m_run[i] && ce1ms) begin
        if (m_rem[i] == 1) begin
          m_exp[i] = 1'b1;
          if (m_mode[i] == 1 && m_period[i] != 0) begin
            m_rem[i] = m_period[i];
          end else begin
            m_run[i] = 1'b0;
            m_rem[i] = 0;
          end
        end else begin
          m_rem[i] = m_rem[i] - 1;
        end
      end
    end
    if (cfg_we && int'(cfg_ch) < NCH) begin
      m_period[cfg_ch] = int'(cfg_period);
      m_mode[cfg_ch]   = int'(cfg_mode);
    end
  endfunction

  task automatic checkModel();
    logic [NCH-1:0]    exp_busy;
    logic [NCH-1:0]    exp_expire;
    logic [NCH*CW-1:0] exp_count;
    for (int i = 0; i < NCH; i++) begin
      exp_busy[i]            = m_run[i];
      exp_expire[i]          = m_exp[i];
      exp_count[i*CW +: CW]  = CW'(m_rem[i]);
    end
    checkOutput("busy", 64'(busy), 64'(exp_busy));
    checkOutput("expire", 64'(expire), 64'(exp_expire));
    checkOutput("count", 64'(count), 64'(exp_count));
`ifdef MS_TIMER_IRQ_EN
    begin
      logic [NCH-1:0] exp_pend;
      for (int i = 0; i < NCH; i++) exp_pend[i] = m_pend[i];
      checkOutput("irq_pend", 64'(irq_pend), 64'(exp_pend));
      checkOutput("irq", 64'(irq), 64'(|exp_pend));
    end
`endif
  endtask

  task automatic clearInputs();
    ce1ms      = 1'b0;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_period = '0;
    cfg_mode   = 1'b0;
    start      = '0;
    stop       = '0;
`ifdef MS_TIMER_IRQ_EN
    irq_clr    = '0;
`endif
  endtask

  // One clock of stimulus: model the edge, take it, check 1 ns later, then
  // drop all request inputs back to idle.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
    checkModel();
    clearInputs();
  endtask

  task automatic configure(input int ch, input int period, input int mode);
    cfg_we     = 1'b1;
    cfg_ch     = CHW'(ch);
    cfg_period = CW'(period);
    cfg_mode   = mode[0];
    applyStimulus();
  endtask

  function automatic logic [CW-1:0] chanCount(input int ch);
    return count[ch*CW +: CW];
  endfunction

  initial begin
    rst_n = 1'b0;
    clearInputs();
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_expire", 64'(expire), 64'd0);
    checkOutput("reset_count", 64'(count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // One-shot ch0, period 3.
    $display("[TB] one-shot channel 0");
    configure(0, 3, 0);
    start[0] = 1'b1;
    applyStimulus();
    checkOutput("os_busy_after_start", 64'(busy[0]), 64'd1);
    checkOutput("os_count_3", 64'(chanCount(0)), 64'd3);
    ce1ms = 1'b1; applyStimulus();
    checkOutput("os_count_2", 64'(chanCount(0)), 64'd2);
    applyStimulus();
    ce1ms = 1'b1; applyStimulus();
    checkOutput("os_count_1", 64'(chanCount(0)), 64'd1);
    checkOutput("os_no_early_expire", 64'(expire[0]), 64'd0);
    ce1ms = 1'b1; applyStimulus();
    checkOutput("os_expire", 64'(expire[0]), 64'd1);
    checkOutput("os_busy_done", 64'(busy[0]), 64'd0);
    checkOutput("os_count_0", 64'(chanCount(0)), 64'd0);
    applyStimulus();
    checkOutput("os_expire_one_cycle", 64'(expire[0]), 64'd0);

    // Periodic ch1, period 2.
    $display("[TB] periodic channel 1");
    configure(1, 2, 1);
    start[1] = 1'b1;
    applyStimulus();
    for (int k = 1; k <= 6; k++) begin
      ce1ms = 1'b1; applyStimulus();
      checkOutput("per_expire", 64'(expire[1]), 64'((k % 2) == 0));
      checkOutput("per_busy", 64'(busy[1]), 64'd1);
      applyStimulus();
    end
    stop[1] = 1'b1;
    applyStimulus();
    checkOutput("per_stop_busy", 64'(busy[1]), 64'd0);
    checkOutput("per_stop_count", 64'(chanCount(1)), 64'd0);
    for (int k = 0; k < 3; k++) begin
      ce1ms = 1'b1; applyStimulus();
    end

    // Disabled channel, then period 1 periodic.
    $display("[TB] period 0 and period 1 on channel 2");
    start[2] = 1'b1;
    applyStimulus();
    checkOutput("p0_busy", 64'(busy[2]), 64'd0);
    ce1ms = 1'b1; applyStimulus();
    checkOutput("p0_no_expire", 64'(expire[2]), 64'd0);
    configure(2, 1, 1);
    start[2] = 1'b1;
    applyStimulus();
    for (int k = 0; k < 3; k++) begin
      ce1ms = 1'b1; applyStimulus();
      checkOutput("p1_expire", 64'(expire[2]), 64'd1);
      applyStimulus();
      checkOutput("p1_expire_gap", 64'(expire[2]), 64'd0);
    end

    // Simultaneous events on ch0.
    $display("[TB] simultaneous events on channel 0");
    start[0] = 1'b1; stop[0] = 1'b1;
    applyStimulus();
    checkOutput("start_stop_idle", 64'(busy[0]), 64'd0);
    configure(0, 2, 1);
    start[0] = 1'b1;
    applyStimulus();
    ce1ms = 1'b1; applyStimulus();
    checkOutput("sim_cnt1", 64'(chanCount(0)), 64'd1);
    ce1ms = 1'b1; start[0] = 1'b1;
    applyStimulus();
    checkOutput("restart_no_expire", 64'(expire[0]), 64'd0);
    checkOutput("restart_reload", 64'(chanCount(0)), 64'd2);
    configure(0, 5, 1);
    checkOutput("cfg_running_untouched", 64'(chanCount(0)), 64'd2);
    ce1ms = 1'b1; applyStimulus();
    ce1ms = 1'b1; applyStimulus();
    checkOutput("cfg_reload_expire", 64'(expire[0]), 64'd1);
    checkOutput("cfg_reload_new", 64'(chanCount(0)), 64'd5);

    // Asynchronous reset with every channel at cnt==1.
    $display("[TB] asynchronous reset mid-count");
    for (int i = 0; i < NCH; i++) configure(i, 2, 1);
    start = '1;
    applyStimulus();
    ce1ms = 1'b1; applyStimulus();
    checkOutput("rst_pre_cnt", 64'(chanCount(3)), 64'd1);
    ce1ms = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_rst_busy", 64'(busy), 64'd0);
    checkOutput("async_rst_expire", 64'(expire), 64'd0);
    checkOutput("async_rst_count", 64'(count), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkModel();
    for (int k = 0; k < 4; k++) begin
      ce1ms = 1'b1; applyStimulus();
      checkOutput("post_rst_no_expire", 64'(expire), 64'd0);
    end

`ifdef MS_TIMER_IRQ_EN
    $display("[TB] interrupt pending on channel 3");
    stop = '1; applyStimulus();
    applyStimulus();
    irq_clr = '1; applyStimulus();
    configure(3, 1, 1);
    start[3] = 1'b1; applyStimulus();
    ce1ms = 1'b1; applyStimulus();
    checkOutput("irq_expire3", 64'(expire[3]), 64'd1);
    applyStimulus();
    checkOutput("irq_pend3_set", 64'(irq_pend[3]), 64'd1);
    checkOutput("irq_set", 64'(irq), 64'd1);
    ce1ms = 1'b1; applyStimulus();
    ce1ms = 1'b1; irq_clr[3] = 1'b1; applyStimulus();
    checkOutput("irq_set_wins", 64'(irq_pend[3]), 64'd1);
    applyStimulus();
    irq_clr[3] = 1'b1; applyStimulus();
    checkOutput("irq_pend3_clr", 64'(irq_pend[3]), 64'd0);
    checkOutput("irq_clr", 64'(irq), 64'd0);
`endif

    // Randomized traffic against the model.
    $display("[TB] randomized phase");
    for (int n = 0; n < 400; n++) begin
      ce1ms = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < NCH; i++) begin
        start[i] = ($urandom_range(0, 15) == 0);
        stop[i]  = ($urandom_range(0, 39) == 0);
      end
      if ($urandom_range(0, 7) == 0) begin
        cfg_we     = 1'b1;
        cfg_ch     = CHW'($urandom_range(0, NCH - 1));
        cfg_period = ($urandom_range(0, 9) == 0) ? CW'(16'hFFFF) : CW'($urandom_range(0, 5));
        cfg_mode   = 1'($urandom_range(0, 1));
      end
`ifdef MS_TIMER_IRQ_EN
      for (int i = 0; i < NCH; i++) irq_clr[i] = ($urandom_range(0, 5) == 0);
`endif
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
